// File: rtl/ats_pkg.sv
// Shared types and constants for the ATS timer array: opcodes, status codes,
// tick rates and the per-counter / per-alarm state records.
package ats_pkg;

    localparam int unsigned ATS_CW      = 16;
    localparam int unsigned CLK_IDX_W   = 4;
    localparam int unsigned CMD_LATENCY = 2;

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_CLK_SET   = 3'd1,
        OP_CLK_START = 3'd2,
        OP_CLK_STOP  = 3'd3,
        OP_ALM_SET   = 3'd4,
        OP_ALM_CLR   = 3'd5,
        OP_CLK_READ  = 3'd6,
        OP_CLK_DOWN  = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_OK    = 2'b01,
        ST_ERR   = 2'b10,
        ST_RDATA = 2'b11
    } stat_e;

    typedef enum logic [1:0] {
        RATE_1X  = 2'b00,
        RATE_2X  = 2'b01,
        RATE_4X  = 2'b10,
        RATE_BAD = 2'b11
    } rate_e;

    typedef struct packed {
        logic              enable;
        logic              down;
        rate_e             rate;
        logic [ATS_CW-1:0] count;
    } clock_t;

    typedef struct packed {
        logic                 enable;
        logic                 loop;
        logic [CLK_IDX_W-1:0] clk_idx;
        logic [ATS_CW-1:0]    value;
        logic [1:0]           fin_cnt;
    } alarm_t;

    // Select the tick enable that matches a counter's programmed rate.
    function automatic logic rate_tick(input rate_e r, input logic t1,
                                       input logic t2, input logic t4);
        case (r)
            RATE_1X: return t1;
            RATE_2X: return t2;
            RATE_4X: return t4;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ats_prescaler.sv
// Free-running 2-bit prescaler producing 1x/2x/4x tick enables for the
// counter array. Never cleared by commands, only by reset.
module ats_prescaler (
    input  logic clk_1x,
    input  logic reset,
    output logic tick_1x,
    output logic tick_2x,
    output logic tick_4x
);

    logic [1:0] pre_q;
    logic [1:0] pre_d;
    logic       tick_2x_q;
    logic       tick_4x_q;

    assign pre_d = pre_q + 2'd1;

    // Ticks are registered copies of the decoded prescaler value.
    always_ff @(posedge clk_1x or posedge reset) begin
        if (reset) begin
            pre_q     <= 2'd0;
            tick_2x_q <= 1'b0;
            tick_4x_q <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            tick_2x_q <= pre_d[0];
            tick_4x_q <= &pre_d;
        end
    end

    assign tick_1x = 1'b1;
    assign tick_2x = tick_2x_q;
    assign tick_4x = tick_4x_q;

endmodule

// File: rtl/ats_timer_array.sv
// Multi-counter / alarm engine with a req/ready command port.
// Define ATS_COUNTDOWN_EN to enable opcode 7 (CLK_DOWN) and down-counting.
module ats_timer_array
    import ats_pkg::*;
#(
    parameter int unsigned CW         = ATS_CW,
    parameter int unsigned NUM_CLOCKS = 16,
    parameter int unsigned NUM_ALARMS = 24
) (
    input  logic                  clk_1x,
    input  logic                  reset,
    input  logic                  req,
    input  logic [2:0]            cmd,
    input  logic [15:0]           arg_a,
    input  logic [CW-1:0]         arg_b,
    output logic                  ready,
    output logic [1:0]            stat,
    output logic [CW-1:0]         rdata,
    output logic [NUM_ALARMS-1:0] data
);

    localparam int unsigned CIW = $clog2(NUM_CLOCKS);
    localparam int unsigned AIW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} fsm_e;

    fsm_e                  state_q;
    logic                  ready_q;
    stat_e                 stat_q;
    logic [CW-1:0]         rdata_q;
    opcode_e               op_q;
    logic [7:0]            tgt_q;
    logic [CLK_IDX_W-1:0]  aclk_q;
    logic                  loop_q;
    rate_e                 rate_q;
    logic [CW-1:0]         val_q;

    clock_t                clk_q [NUM_CLOCKS];
    clock_t                clk_d [NUM_CLOCKS];
    alarm_t                alm_q [NUM_ALARMS];
    alarm_t                alm_d [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] data_q;
    logic [NUM_ALARMS-1:0] data_d;
    logic [NUM_CLOCKS-1:0] upd_c;
    logic [CIW-1:0]        sel_c [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] match_c;

    logic                  exec_c;
    logic                  err_c;
    logic                  clk_ok_c;
    logic                  alm_ok_c;
    logic                  aclk_ok_c;
    logic                  clk_wr_c;
    logic                  alm_wr_c;
    logic [CW-1:0]         rd_val_c;
    logic                  tick_1x;
    logic                  tick_2x;
    logic                  tick_4x;

    ats_prescaler u_prescaler (
        .clk_1x  (clk_1x),
        .reset   (reset),
        .tick_1x (tick_1x),
        .tick_2x (tick_2x),
        .tick_4x (tick_4x)
    );

    // The alarm clock field can only address 2^CLK_IDX_W counters.
    if (NUM_CLOCKS >= (1 << CLK_IDX_W)) begin : g_aclk_all
        assign aclk_ok_c = 1'b1;
    end else begin : g_aclk_cmp
        assign aclk_ok_c = 32'(aclk_q) < NUM_CLOCKS;
    end

    // Command decode and error classification for the EXEC cycle.
    always_comb begin
        exec_c   = (state_q == S_EXEC);
        clk_ok_c = 32'(tgt_q) < NUM_CLOCKS;
        alm_ok_c = 32'(tgt_q) < NUM_ALARMS;
        rd_val_c = CW'(clk_q[CIW'(tgt_q)].count);
        err_c    = 1'b0;
        case (op_q)
            OP_NOP:                             err_c = 1'b0;
            OP_CLK_SET, OP_CLK_STOP, OP_CLK_READ: err_c = !clk_ok_c;
            OP_CLK_START:                       err_c = !clk_ok_c || (rate_q == RATE_BAD);
            OP_ALM_SET:                         err_c = !alm_ok_c || !aclk_ok_c;
            OP_ALM_CLR:                         err_c = !alm_ok_c;
`ifdef ATS_COUNTDOWN_EN
            OP_CLK_DOWN:                        err_c = !clk_ok_c || (rate_q == RATE_BAD);
`else
            OP_CLK_DOWN:                        err_c = 1'b1;
`endif
            default:                            err_c = 1'b1;
        endcase
        clk_wr_c = exec_c && !err_c &&
                   (op_q inside {OP_CLK_SET, OP_CLK_START, OP_CLK_STOP, OP_CLK_DOWN});
        alm_wr_c = exec_c && !err_c && (op_q inside {OP_ALM_SET, OP_ALM_CLR});
    end

    // Counter next state; a command write on the same edge discards the tick.
    always_comb begin
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            clk_d[i] = clk_q[i];
            upd_c[i] = 1'b0;
            if (clk_wr_c && (CIW'(tgt_q) == CIW'(i))) begin
                case (op_q)
                    OP_CLK_SET: begin
                        clk_d[i].count = ATS_CW'(val_q);
                        clk_d[i].down  = 1'b0;
                    end
                    OP_CLK_START: begin
                        clk_d[i].enable = 1'b1;
                        clk_d[i].rate   = rate_q;
                        clk_d[i].down   = 1'b0;
                    end
                    OP_CLK_STOP: clk_d[i].enable = 1'b0;
`ifdef ATS_COUNTDOWN_EN
                    OP_CLK_DOWN: begin
                        clk_d[i].count  = ATS_CW'(val_q);
                        clk_d[i].down   = 1'b1;
                        clk_d[i].enable = 1'b1;
                        clk_d[i].rate   = rate_q;
                    end
`endif
                    default: ;
                endcase
            end else if (clk_q[i].enable &&
                         rate_tick(clk_q[i].rate, tick_1x, tick_2x, tick_4x)) begin
`ifdef ATS_COUNTDOWN_EN
                if (clk_q[i].down) begin
                    if (clk_q[i].count != '0) begin
                        clk_d[i].count = clk_q[i].count - ATS_CW'(1);
                        upd_c[i]       = 1'b1;
                    end
                    if (clk_q[i].count <= ATS_CW'(1)) clk_d[i].enable = 1'b0;
                end else
`endif
                begin
                    clk_d[i].count = ATS_CW'(CW'(clk_q[i].count) + CW'(1));
                    upd_c[i]       = 1'b1;
                end
            end
        end
    end

    // Alarm next state; flags hold for the match cycle plus one more.
    always_comb begin
        for (int k = 0; k < NUM_ALARMS; k++) begin
            alm_d[k]   = alm_q[k];
            data_d[k]  = 1'b0;
            sel_c[k]   = CIW'(alm_q[k].clk_idx);
            match_c[k] = alm_q[k].enable && upd_c[sel_c[k]] &&
                         (CW'(clk_d[sel_c[k]].count) == CW'(alm_q[k].value));
            if (alm_wr_c && (AIW'(tgt_q) == AIW'(k))) begin
                if (op_q == OP_ALM_SET) begin
                    alm_d[k].enable  = 1'b1;
                    alm_d[k].loop    = loop_q;
                    alm_d[k].clk_idx = aclk_q;
                    alm_d[k].value   = ATS_CW'(val_q);
                end else begin
                    alm_d[k].enable  = 1'b0;
                end
                alm_d[k].fin_cnt = 2'd0;
            end else if (match_c[k]) begin
                alm_d[k].fin_cnt = 2'd1;
                data_d[k]        = 1'b1;
                if (!alm_q[k].loop) alm_d[k].enable = 1'b0;
            end else if (alm_q[k].fin_cnt != 2'd0) begin
                alm_d[k].fin_cnt = alm_q[k].fin_cnt - 2'd1;
                data_d[k]        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_1x or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CLOCKS; i++) clk_q[i] <= '0;
            for (int k = 0; k < NUM_ALARMS; k++) alm_q[k] <= '0;
            data_q <= '0;
        end else begin
            clk_q  <= clk_d;
            alm_q  <= alm_d;
            data_q <= data_d;
        end
    end

    // Command FSM: IDLE accepts, EXEC applies, RESP presents status for one cycle.
    always_ff @(posedge clk_1x or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            stat_q  <= ST_IDLE;
            rdata_q <= '0;
            op_q    <= OP_NOP;
            tgt_q   <= '0;
            aclk_q  <= '0;
            loop_q  <= 1'b0;
            rate_q  <= RATE_1X;
            val_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req && ready_q) begin
                        op_q    <= opcode_e'(cmd);
                        tgt_q   <= arg_a[15:8];
                        aclk_q  <= arg_a[7:4];
                        loop_q  <= arg_a[2];
                        rate_q  <= rate_e'(arg_a[1:0]);
                        val_q   <= arg_b;
                        ready_q <= 1'b0;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state_q <= S_RESP;
                    if (err_c) begin
                        stat_q  <= ST_ERR;
                        rdata_q <= '0;
                    end else if (op_q == OP_CLK_READ) begin
                        stat_q  <= ST_RDATA;
                        rdata_q <= rd_val_c;
                    end else begin
                        stat_q  <= ST_OK;
                        rdata_q <= '0;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    stat_q  <= ST_IDLE;
                    rdata_q <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    stat_q  <= ST_IDLE;
                    rdata_q <= '0;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign stat  = stat_q;
    assign rdata = rdata_q;
    assign data  = data_q;

endmodule
